// File: rtl/spi_rgb_pkg.sv
// Shared constants for the SPI RGB register slave: register map,
// reset defaults and controller state encoding.
package spi_rgb_pkg;

    localparam logic [6:0] ADDR_SPEED = 7'h00;
    localparam logic [6:0] ADDR_MODE  = 7'h01;
    localparam logic [6:0] ADDR_R     = 7'h02;
    localparam logic [6:0] ADDR_G     = 7'h03;
    localparam logic [6:0] ADDR_B     = 7'h04;
    localparam logic [6:0] ADDR_ID    = 7'h05;

    localparam logic [4:0] DEF_SPEED = 5'd16;
    localparam logic [2:0] DEF_MODE  = 3'b111;
    localparam logic [7:0] DEF_ID    = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        WR_DATA,
        RD_DATA
    } state_t;

    // Only the writable registers raise the update strobe.
    function automatic logic is_rw_reg(input logic [6:0] a);
        return a <= ADDR_B;
    endfunction

endpackage

// File: rtl/spi_rgb_regs_if.sv
// SPI pin bundle between a host (master) and the register slave.
interface spi_rgb_regs_if;

    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sck, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with rise/fall detect.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_rgb_regs.sv
// SPI mode-0 slave register file driving speed, per-channel mode and
// static brightness of the RGB cycle stages, with readback and strobe.
module spi_rgb_regs
    import spi_rgb_pkg::*;
#(
    parameter logic [4:0] DEFAULT_SPEED = DEF_SPEED,
    parameter logic [2:0] DEFAULT_MODE  = DEF_MODE,
    parameter logic [7:0] ID_VALUE      = DEF_ID
) (
    input  logic       clk,
    input  logic       rst,
    spi_rgb_regs_if.slave spi,
    output logic [4:0] o_speed,
    output logic [2:0] o_mode,
    output logic [7:0] o_bright_r,
    output logic [7:0] o_bright_g,
    output logic [7:0] o_bright_b,
    output logic       o_update,
    output logic [6:0] o_upd_addr
);

    logic sck_q, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge u_sck (
        .clk(clk), .rst(rst), .d(spi.spi_sck),
        .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge u_cs (
        .clk(clk), .rst(rst), .d(spi.spi_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge u_mosi (
        .clk(clk), .rst(rst), .d(spi.spi_mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_edges = ^{sck_q, mosi_rise, mosi_fall};

    state_t      state, state_nx;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx;
    logic [7:0]  tx;
    logic [6:0]  addr;
    logic        miso;
    logic        in_frame;
    logic        byte_done;
    logic        wr_commit;
    logic [7:0]  rx_byte;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;

    assign in_frame = !cs_q && (state == CMD || state == WR_DATA
                                || state == RD_DATA);
    assign rx_byte   = {rx[6:0], mosi_q};
    assign byte_done = in_frame && sck_rise && (bit_cnt == 3'd7);
    assign wr_commit = byte_done && (state == WR_DATA);

    always_ff @(posedge clk) begin
        if (!rst) state <= WAIT_CS;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_CS: if (cs_q) state_nx = IDLE;
            IDLE:    if (cs_fall) state_nx = CMD;
            CMD:     if (byte_done)
                         state_nx = rx_byte[7] ? RD_DATA : WR_DATA;
            default: state_nx = state;
        endcase
        if (cs_rise) state_nx = IDLE;
    end

    // The command byte selects its own address; data bytes prefetch the next.
    assign rd_addr = (state == CMD) ? rx_byte[6:0] : addr + 7'd1;

    always_comb begin
        rd_data = 8'h00;
        unique case (rd_addr)
            ADDR_SPEED: rd_data = {3'b000, o_speed};
            ADDR_MODE:  rd_data = {5'b00000, o_mode};
            ADDR_R:     rd_data = o_bright_r;
            ADDR_G:     rd_data = o_bright_g;
            ADDR_B:     rd_data = o_bright_b;
            ADDR_ID:    rd_data = ID_VALUE;
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= 3'd0;
            rx         <= 8'h00;
            tx         <= 8'h00;
            addr       <= 7'd0;
            miso       <= 1'b0;
            o_speed    <= DEFAULT_SPEED;
            o_mode     <= DEFAULT_MODE;
            o_bright_r <= 8'h00;
            o_bright_g <= 8'h00;
            o_bright_b <= 8'h00;
            o_update   <= 1'b0;
            o_upd_addr <= 7'd0;
        end else begin
            o_update <= 1'b0;
            if (!in_frame) begin
                bit_cnt <= 3'd0;
                rx      <= 8'h00;
                tx      <= 8'h00;
                miso    <= 1'b0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx      <= rx_byte;
                if (byte_done) begin
                    if (state == CMD) begin
                        addr <= rx_byte[6:0];
                        if (rx_byte[7]) tx <= rd_data;
                    end else begin
                        addr <= addr + 7'd1;
                        if (state == RD_DATA) tx <= rd_data;
                    end
                end
            end else if (sck_fall) begin
                miso <= tx[7];
                tx   <= {tx[6:0], 1'b0};
            end

            if (wr_commit) begin
                o_update <= is_rw_reg(addr);
                if (is_rw_reg(addr)) o_upd_addr <= addr;
                unique case (1'b1)
                    (addr == ADDR_SPEED): o_speed    <= rx_byte[4:0];
                    (addr == ADDR_MODE):  o_mode     <= rx_byte[2:0];
                    (addr == ADDR_R):     o_bright_r <= rx_byte;
                    (addr == ADDR_G):     o_bright_g <= rx_byte;
                    (addr == ADDR_B):     o_bright_b <= rx_byte;
                    default: ;
                endcase
            end
        end
    end

    assign spi.spi_miso    = miso;
    assign spi.spi_miso_oe = !cs_q && (state != WAIT_CS);

endmodule

// File: tb/tb_spi_rgb_regs.sv
// Randomised scoreboard bench for spi_rgb_regs against an array-based
// model of the register map.
module tb_spi_rgb_regs;

    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_rgb_regs_if bus();

    logic [4:0] o_speed;
    logic [2:0] o_mode;
    logic [7:0] o_bright_r, o_bright_g, o_bright_b;
    logic       o_update;
    logic [6:0] o_upd_addr;

    spi_rgb_regs dut (
        .clk(clk),
        .rst(rst),
        .spi(bus),
        .o_speed(o_speed),
        .o_mode(o_mode),
        .o_bright_r(o_bright_r),
        .o_bright_g(o_bright_g),
        .o_bright_b(o_bright_b),
        .o_update(o_update),
        .o_upd_addr(o_upd_addr)
    );

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] v;
    } upd_t;

    logic [7:0] mem [0:4];
    upd_t       expq[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] exp_rd[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic model_reset();
        mem[0] = 8'd16;
        mem[1] = 8'd7;
        mem[2] = 8'd0;
        mem[3] = 8'd0;
        mem[4] = 8'd0;
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a < 7'd5) return mem[a];
        if (a == 7'd5) return 8'hA5;
        return 8'h00;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [7:0] v);
        upd_t u;
        if (a < 7'd5) begin
            if (a == 7'd0)      mem[a] = v & 8'h1F;
            else if (a == 7'd1) mem[a] = v & 8'h07;
            else                mem[a] = v;
            u.a = a;
            u.v = mem[a];
            expq.push_back(u);
        end
    endtask

    function automatic logic [7:0] dut_reg(input logic [6:0] a);
        case (a)
            7'd0:    return {3'b000, o_speed};
            7'd1:    return {5'b00000, o_mode};
            7'd2:    return o_bright_r;
            7'd3:    return o_bright_g;
            7'd4:    return o_bright_b;
            default: return 8'hEE;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_speed"}, {24'b0, dut_reg(7'd0)}, {24'b0, mem[0]});
        chk({tag, "_mode"},  {24'b0, dut_reg(7'd1)}, {24'b0, mem[1]});
        chk({tag, "_r"},     {24'b0, dut_reg(7'd2)}, {24'b0, mem[2]});
        chk({tag, "_g"},     {24'b0, dut_reg(7'd3)}, {24'b0, mem[3]});
        chk({tag, "_b"},     {24'b0, dut_reg(7'd4)}, {24'b0, mem[4]});
    endtask

    task automatic xfer(input logic [7:0] d, input int nbits,
                        output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.spi_mosi = d[i];
            #HALF;
            r[i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            #HALF;
            bus.spi_sck = 1'b0;
        end
    endtask

    // Expectations are derived from txq before the frame is clocked out.
    task automatic do_frame(input string tag);
        logic [7:0] r;
        logic [6:0] a;
        int n;
        n = txq.size() - 1;
        a = txq[0][6:0];
        exp_rd.delete();
        rxq.delete();
        for (int k = 0; k < n; k++) begin
            if (txq[0][7]) exp_rd.push_back(model_read(a + 7'(k)));
            else model_write(a + 7'(k), txq[k + 1]);
        end
        bus.spi_cs_n = 1'b0;
        #(2 * HALF);
        chk({tag, "_oe"}, {31'b0, bus.spi_miso_oe}, 32'd1);
        foreach (txq[i]) begin
            xfer(txq[i], 8, r);
            rxq.push_back(r);
        end
        #(2 * HALF);
        bus.spi_cs_n = 1'b1;
        #(4 * HALF);
        if (txq[0][7]) begin
            chk({tag, "_cmd_miso"}, {24'b0, rxq[0]}, 32'h0);
            for (int k = 0; k < n; k++)
                chk({tag, "_rd"}, {24'b0, rxq[k + 1]}, {24'b0, exp_rd[k]});
        end
        check_regs(tag);
    endtask

    always @(negedge clk) begin
        if (rst && o_update) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: got addr %0h want none",
                         o_upd_addr);
            end else begin
                upd_t u;
                u = expq.pop_front();
                chk("upd_addr", {25'b0, o_upd_addr}, {25'b0, u.a});
                chk("upd_val", {24'b0, dut_reg(u.a)}, {24'b0, u.v});
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        logic [6:0] pick [0:9];
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_regs("reset");
        chk("reset_oe", {31'b0, bus.spi_miso_oe}, 32'd0);
        chk("reset_miso", {31'b0, bus.spi_miso}, 32'd0);
        chk("reset_upd", {31'b0, o_update}, 32'd0);
        chk("reset_upd_addr", {25'b0, o_upd_addr}, 32'd0);
        repeat (4) @(negedge clk);

        txq = '{8'h00, 8'h0C};
        do_frame("speed12");
        txq = '{8'h02, 8'h10, 8'h20, 8'h30};
        do_frame("burst");
        txq = '{8'h85, 8'h00};
        do_frame("id_read");
        txq = '{8'h00, 8'h1F};
        do_frame("speed31");

        bus.spi_cs_n = 1'b0;
        #(2 * HALF);
        xfer(8'h01, 5, r);
        #(2 * HALF);
        bus.spi_cs_n = 1'b1;
        #(4 * HALF);
        check_regs("partial");
        txq = '{8'h01, 8'h02};
        do_frame("mode2");

        bus.spi_cs_n = 1'b0;
        #(2 * HALF);
        xfer(8'h02, 8, r);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        xfer(8'h55, 8, r);
        #(2 * HALF);
        bus.spi_cs_n = 1'b1;
        #(4 * HALF);
        check_regs("rst_mid");
        txq = '{8'h02, 8'h55};
        do_frame("after_rst");

        bus.spi_cs_n = 1'b0;
        #(2 * HALF);
        bus.spi_cs_n = 1'b1;
        #(4 * HALF);
        check_regs("empty_cs");

        pick = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04,
                 7'h05, 7'h06, 7'h7E, 7'h7F, 7'h7D};
        for (int f = 0; f < 40; f++) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            a  = pick[$urandom_range(0, 9)];
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            txq.delete();
            txq.push_back({rw, a});
            for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
            do_frame(rw ? "rnd_rd" : "rnd_wr");
        end

        repeat (20) @(negedge clk);
        chk("strobes_drained", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
